// File: rtl/serial_cmd_initiator_pkg.sv
// Shared definitions for the serial command initiator: opcodes, FSM states, byte widths.
package serial_cmd_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NARGS_W = 3;
    localparam int unsigned NRESP_W = 4;

    localparam logic [BYTE_W-1:0] CMD_VERSION       = 8'd0;
    localparam logic [BYTE_W-1:0] CMD_DEADTICKS     = 8'd1;
    localparam logic [BYTE_W-1:0] CMD_FIRINGTICKS   = 8'd2;
    localparam logic [BYTE_W-1:0] CMD_TOGGLE_OUT    = 8'd3;
    localparam logic [BYTE_W-1:0] CMD_TOGGLE_CLKSRC = 8'd4;
    localparam logic [BYTE_W-1:0] CMD_SET_PHASE     = 8'd5;
    localparam logic [BYTE_W-1:0] CMD_MASK1         = 8'd6;
    localparam logic [BYTE_W-1:0] CMD_MASK2         = 8'd7;
    localparam logic [BYTE_W-1:0] CMD_PASSTHRU      = 8'd8;
    localparam logic [BYTE_W-1:0] CMD_READ_HIST     = 8'd10;
    localparam logic [BYTE_W-1:0] CMD_VETOLAST      = 8'd11;
    localparam logic [BYTE_W-1:0] CMD_RESET_PLL     = 8'd13;
    localparam logic [BYTE_W-1:0] CMD_VETO_CYCLES   = 8'd14;
    localparam logic [BYTE_W-1:0] CMD_CLK_AS_INPUT  = 8'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_RECV,
        ST_DONE
    } cmd_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/serial_cmd_initiator_if.sv
// Command request, UART tx/rx handshake and response bundle for serial_cmd_initiator.
interface serial_cmd_initiator_if #(
    parameter int unsigned MAX_ARGS = 4,
    parameter int unsigned MAX_RESP = 8
);
    import serial_cmd_pkg::*;

    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [BYTE_W-1:0]            cmd_opcode;
    logic [NARGS_W-1:0]           cmd_nargs;
    logic [BYTE_W*MAX_ARGS-1:0]   cmd_args;
    logic [NRESP_W-1:0]           cmd_nresp;
    logic                         txBusy;
    logic                         txStart;
    logic [BYTE_W-1:0]            txData;
    logic                         rxReady;
    logic [BYTE_W-1:0]            rxData;
    logic                         resp_valid;
    logic [BYTE_W*MAX_RESP-1:0]   resp_data;
    logic [NRESP_W-1:0]           resp_count;
    logic                         timeout;
    logic                         busy;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_nargs, cmd_args, cmd_nresp,
               txBusy, rxReady, rxData,
        output cmd_ready, txStart, txData, resp_valid, resp_data,
               resp_count, timeout, busy
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_nargs, cmd_args, cmd_nresp,
               txBusy, rxReady, rxData,
        input  cmd_ready, txStart, txData, resp_valid, resp_data,
               resp_count, timeout, busy
    );

endinterface

// File: rtl/serial_cmd_initiator_timer.sv
// Inactivity timer: expires after TIMEOUT_CYCLES enabled cycles without a clear.
module cmd_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 32'd1;
        end
    end

    // A clear in the expiry cycle wins, so a late byte suppresses the timeout.
    always_comb begin
        expired = enable && !clear && (count == 32'(TIMEOUT_CYCLES - 1));
    end

endmodule

// File: rtl/serial_cmd_initiator.sv
// Byte-serial command initiator: sends opcode+args over UART tx, collects the reply from rx.
// Define SERIAL_INIT_STATS_EN to add the stray_count/timeout_count statistics outputs.
module serial_cmd_initiator
    import serial_cmd_pkg::*;
#(
    parameter int unsigned MAX_ARGS       = 4,
    parameter int unsigned MAX_RESP       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_cmd_initiator_if.master bus
`ifdef SERIAL_INIT_STATS_EN
    ,
    output logic [7:0]             stray_count,
    output logic [7:0]             timeout_count
`endif
);
    localparam logic [NARGS_W-1:0] MAX_ARGS_L = NARGS_W'(MAX_ARGS);
    localparam logic [NRESP_W-1:0] MAX_RESP_L = NRESP_W'(MAX_RESP);

    cmd_state_t                 state;
    logic [BYTE_W-1:0]          opcode_q;
    logic [BYTE_W*MAX_ARGS-1:0] args_q;
    logic [NARGS_W-1:0]         nargs_q;
    logic [NARGS_W-1:0]         idx;
    logic [NRESP_W-1:0]         nresp_q;
    logic [BYTE_W-1:0]          tx_byte;
    logic                       tmr_clear;
    logic                       tmr_en;
    logic                       tmr_expired;

    always_comb begin
        tx_byte = opcode_q;
        for (int unsigned k = 0; k < MAX_ARGS; k++) begin
            if (idx == NARGS_W'(k + 1)) tx_byte = args_q[BYTE_W*k +: BYTE_W];
        end
    end

    always_comb begin
        tmr_en    = (state == ST_RECV);
        tmr_clear = (state != ST_RECV) || bus.rxReady;
    end

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expired(tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            bus.txStart    <= 1'b0;
            bus.txData     <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_count <= '0;
            bus.timeout    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.cmd_ready  <= 1'b1;
            opcode_q       <= '0;
            args_q         <= '0;
            nargs_q        <= '0;
            nresp_q        <= '0;
            idx            <= '0;
        end else begin
            bus.txStart    <= 1'b0;
            bus.resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        opcode_q       <= bus.cmd_opcode;
                        args_q         <= bus.cmd_args;
                        nargs_q        <= (bus.cmd_nargs > MAX_ARGS_L) ? MAX_ARGS_L : bus.cmd_nargs;
                        nresp_q        <= (bus.cmd_nresp > MAX_RESP_L) ? MAX_RESP_L : bus.cmd_nresp;
                        bus.resp_data  <= '0;
                        bus.resp_count <= '0;
                        bus.timeout    <= 1'b0;
                        idx            <= '0;
                        bus.cmd_ready  <= 1'b0;
                        bus.busy       <= 1'b1;
                        state          <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!bus.txBusy) begin
                        bus.txData  <= tx_byte;
                        bus.txStart <= 1'b1;
                        state       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (idx < nargs_q) begin
                        idx   <= idx + NARGS_W'(1);
                        state <= ST_SEND;
                    end else if (nresp_q == '0) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (bus.rxReady) begin
                        for (int unsigned j = 0; j < MAX_RESP; j++) begin
                            if (bus.resp_count == NRESP_W'(j)) bus.resp_data[BYTE_W*j +: BYTE_W] <= bus.rxData;
                        end
                        bus.resp_count <= bus.resp_count + NRESP_W'(1);
                        if (bus.resp_count + NRESP_W'(1) == nresp_q) state <= ST_DONE;
                    end else if (tmr_expired) begin
                        bus.timeout <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus.resp_valid <= 1'b1;
                    bus.cmd_ready  <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: begin
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_INIT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stray_count   <= '0;
            timeout_count <= '0;
        end else begin
            if (bus.rxReady && (state != ST_RECV)) stray_count <= sat_inc8(stray_count);
            if ((state == ST_RECV) && tmr_expired) timeout_count <= sat_inc8(timeout_count);
        end
    end
`endif

endmodule

// File: tb/tb_serial_cmd_initiator.sv
// Directed bench for serial_cmd_initiator with a cycle-level expectation model and literal pins.
module tb_serial_cmd_initiator;
    import serial_cmd_pkg::*;

    localparam int unsigned MA = 4;
    localparam int unsigned MR = 8;
    localparam int unsigned TO = 1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   tx_len = 1;

    serial_cmd_initiator_if #(.MAX_ARGS(MA), .MAX_RESP(MR)) bus ();

`ifdef SERIAL_INIT_STATS_EN
    logic [7:0] stray_count;
    logic [7:0] timeout_count;
`endif

    serial_cmd_initiator #(
        .MAX_ARGS      (MA),
        .MAX_RESP      (MR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef SERIAL_INIT_STATS_EN
        ,
        .stray_count  (stray_count),
        .timeout_count(timeout_count)
`endif
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic expire(input string name);
        total++;
        bad++;
        $display("FAIL %s at cycle %0d: bound expired, wanted event", name, cyc);
    endtask

    // Transmitter stand-in: busy for tx_len cycles starting in the txStart cycle.
    initial begin
        int left = 0;
        bus.txBusy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.txStart) left = tx_len;
            bus.txBusy = (left > 0);
            if (left > 0) left--;
        end
    end

    // ---------------- expectation model ----------------
    typedef enum int {PH_IDLE, PH_SEND, PH_RECV, PH_DONE} phase_t;
    phase_t      phase = PH_IDLE;
    logic        rst_prev = 1'b1;
    logic [7:0]  txq[$];
    int          m_nresp = 0, rx_cnt = 0;
    int          exp_tx = -1, exp_valid = -1, send_from = 0, recv_from = 0, anchor = 0;
    logic        m_busy, nx_busy, m_timeout, nx_timeout;
    logic [3:0]  m_count, nx_count;
    logic [63:0] m_data, nx_data;
    logic [7:0]  m_txdata, nx_txdata, m_stray, nx_stray, m_tcount, nx_tcount;

    task automatic model_step();
        int  n = cyc;
        int  na, nr;
        logic in_recv;
        if (rst_prev) begin
            m_busy = 0; m_timeout = 0; m_count = 0; m_data = '0; m_txdata = '0;
            m_stray = '0; m_tcount = '0;
            phase = PH_IDLE; txq.delete(); exp_tx = -1; exp_valid = -1;
        end else begin
            m_busy = nx_busy; m_timeout = nx_timeout; m_count = nx_count; m_data = nx_data;
            m_txdata = nx_txdata; m_stray = nx_stray; m_tcount = nx_tcount;
        end
        chk("txStart", bus.txStart, n == exp_tx);
        chk("txData", bus.txData, m_txdata);
        chk("resp_valid", bus.resp_valid, n == exp_valid);
        chk("busy", bus.busy, m_busy);
        chk("cmd_ready", bus.cmd_ready, !m_busy);
        chk("resp_count", bus.resp_count, m_count);
        chk("resp_data", bus.resp_data, m_data);
        chk("timeout", bus.timeout, m_timeout);
`ifdef SERIAL_INIT_STATS_EN
        chk("stray_count", stray_count, m_stray);
        chk("timeout_count", timeout_count, m_tcount);
`endif
        nx_busy = m_busy; nx_timeout = m_timeout; nx_count = m_count; nx_data = m_data;
        nx_txdata = m_txdata; nx_stray = m_stray; nx_tcount = m_tcount;
        if (!reset) begin
            in_recv = (phase == PH_RECV) && (n >= recv_from);
            if (bus.rxReady && !in_recv && m_stray != 8'hFF) nx_stray = m_stray + 8'd1;
            case (phase)
                PH_IDLE: if (bus.cmd_valid && !m_busy) begin
                    na = (int'(bus.cmd_nargs) > MA) ? MA : int'(bus.cmd_nargs);
                    nr = (int'(bus.cmd_nresp) > MR) ? MR : int'(bus.cmd_nresp);
                    txq.delete();
                    txq.push_back(bus.cmd_opcode);
                    for (int k = 0; k < na; k++) txq.push_back(bus.cmd_args[8*k +: 8]);
                    m_nresp = nr; rx_cnt = 0;
                    nx_busy = 1; nx_count = 0; nx_data = '0; nx_timeout = 0;
                    send_from = n + 1; phase = PH_SEND;
                end
                PH_SEND: if (n >= send_from && !bus.txBusy) begin
                    exp_tx = n + 1;
                    nx_txdata = txq.pop_front();
                    send_from = n + 2;
                    if (txq.size() == 0) begin
                        if (m_nresp == 0) begin
                            exp_valid = n + 3; phase = PH_DONE;
                        end else begin
                            recv_from = n + 2; anchor = n + 1; phase = PH_RECV;
                        end
                    end
                end
                PH_RECV: if (in_recv) begin
                    if (bus.rxReady) begin
                        nx_data[8*rx_cnt +: 8] = bus.rxData;
                        rx_cnt++;
                        nx_count = 4'(rx_cnt);
                        if (rx_cnt == m_nresp) begin
                            exp_valid = n + 2; phase = PH_DONE;
                        end else begin
                            anchor = n;
                        end
                    end else if (n == anchor + int'(TO)) begin
                        nx_timeout = 1;
                        if (m_tcount != 8'hFF) nx_tcount = m_tcount + 8'd1;
                        exp_valid = n + 2; phase = PH_DONE;
                    end
                end
                PH_DONE: if (n + 1 == exp_valid) begin
                    nx_busy = 0; phase = PH_IDLE;
                end
                default: phase = PH_IDLE;
            endcase
        end
        rst_prev = reset;
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input logic [7:0] op, input logic [2:0] na, input logic [31:0] args,
                            input logic [3:0] nr);
        int i;
        for (i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (bus.cmd_ready) break;
        end
        if (i == 300) expire("cmd_ready");
        bus.cmd_opcode = op; bus.cmd_nargs = na; bus.cmd_args = args; bus.cmd_nresp = nr;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_tx(input int limit, output int c);
        c = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #2;
            if (bus.txStart) begin c = cyc; break; end
        end
        if (c < 0) expire("wait_tx");
    endtask

    task automatic wait_valid(input int limit, output int c);
        c = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #2;
            if (bus.resp_valid) begin c = cyc; break; end
        end
        if (c < 0) expire("wait_valid");
    endtask

    task automatic rx_byte(input logic [7:0] b, output int c);
        @(posedge clk); #1;
        bus.rxReady = 1'b1; bus.rxData = b; c = cyc;
        @(posedge clk); #1;
        bus.rxReady = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int g1, g2, v, r;
        logic [7:0] exp_seq [5];
        bus.cmd_valid = 0; bus.cmd_opcode = '0; bus.cmd_nargs = '0; bus.cmd_args = '0;
        bus.cmd_nresp = '0; bus.rxReady = 0; bus.rxData = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset busy", bus.busy, 1'b0);
        chk("reset cmd_ready", bus.cmd_ready, 1'b1);
        chk("reset txStart", bus.txStart, 1'b0);

        // version query
        send_cmd(CMD_VERSION, 3'd0, 32'h0, 4'd1);
        wait_tx(20, g1);
        chk("ver txData", bus.txData, 8'h00);
        idle(3);
        rx_byte(8'h11, r);
        wait_valid(20, v);
        chk("ver latency", 64'(v - r), 64'd2);
        chk("ver data", bus.resp_data[7:0], 8'h11);
        chk("ver count", bus.resp_count, 4'd1);
        chk("ver timeout", bus.timeout, 1'b0);

        // set deadticks, no response
        send_cmd(CMD_DEADTICKS, 3'd1, 32'h0000_000A, 4'd0);
        wait_tx(20, g1);
        chk("dt byte0", bus.txData, 8'h01);
        wait_tx(20, g2);
        chk("dt byte1", bus.txData, 8'h0A);
        chk("dt spacing", 64'(g2 - g1), 64'd2);
        wait_valid(20, v);
        chk("dt latency", 64'(v - g2), 64'd2);
        chk("dt count", bus.resp_count, 4'd0);

        // backpressure: transmitter busy for 100 cycles after each byte
        tx_len = 100;
        send_cmd(CMD_SET_PHASE, 3'd1, 32'h0000_0003, 4'd0);
        wait_tx(20, g1);
        wait_tx(200, g2);
        chk("bp spacing", 64'(g2 - g1), 64'd101);
        chk("bp byte1", bus.txData, 8'h03);
        wait_valid(20, v);
        tx_len = 1;
        idle(110);

        // timeout after two of four bytes
        send_cmd(CMD_READ_HIST, 3'd0, 32'h0, 4'd4);
        wait_tx(20, g1);
        idle(5);
        rx_byte(8'hAA, r);
        idle(10);
        rx_byte(8'hBB, r);
        wait_valid(TO + 50, v);
        chk("to latency", 64'(v - r), 64'(TO + 2));
        chk("to flag", bus.timeout, 1'b1);
        chk("to count", bus.resp_count, 4'd2);
        chk("to data", bus.resp_data[15:0], 16'hBBAA);

        // clamping: 7 args requested -> 4 sent, 15 bytes expected -> 8 collected
        exp_seq = '{8'h06, 8'h11, 8'h22, 8'h33, 8'h44};
        send_cmd(CMD_MASK1, 3'd7, 32'h4433_2211, 4'd15);
        for (int i = 0; i < 5; i++) begin
            wait_tx(20, g1);
            chk("clamp tx", bus.txData, exp_seq[i]);
        end
        for (int i = 0; i < 8; i++) rx_byte(8'hC0 + 8'(i), r);
        wait_valid(20, v);
        chk("clamp count", bus.resp_count, 4'd8);
        chk("clamp data", bus.resp_data, 64'hC7C6_C5C4_C3C2_C1C0);
        chk("clamp no extra tx", 64'(txq.size()), 64'd0);

        // reset during the gap after the opcode
        send_cmd(CMD_MASK2, 3'd2, 32'h0000_5566, 4'd1);
        wait_tx(20, g1);
        reset = 1'b1;
        @(posedge clk); #2;
        chk("rst txStart", bus.txStart, 1'b0);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst cmd_ready", bus.cmd_ready, 1'b1);
        reset = 1'b0;
        idle(3);
        send_cmd(CMD_VERSION, 3'd0, 32'h0, 4'd1);
        wait_tx(20, g1);
        rx_byte(8'h22, r);
        wait_valid(20, v);
        chk("post-rst data", bus.resp_data[7:0], 8'h22);
        chk("post-rst timeout", bus.timeout, 1'b0);

`ifdef SERIAL_INIT_STATS_EN
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_byte(8'h5A, r);
            idle(1);
        end
        send_cmd(CMD_VETOLAST, 3'd0, 32'h0, 4'd1);
        wait_valid(TO + 50, v);
        chk("st timeout", bus.timeout, 1'b1);
        chk("st stray3", stray_count, 8'd3);
        chk("st tcount1", timeout_count, 8'd1);
        @(posedge clk); #1 bus.rxReady = 1'b1;
        repeat (300) @(posedge clk);
        #1 bus.rxReady = 1'b0;
        @(posedge clk); #2;
        chk("st stray sat", stray_count, 8'd255);
`endif

        idle(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
